// File: rtl/stream_demux3_if.sv
// Stream bundle for the 1-to-3 demultiplexer: one input stream and three
// output channels that share a single payload bus.
//
// Handshake: a beat moves across a link on every rising clock edge where
// valid and ready are both high. The producer must hold valid and its
// payload stable until that edge. Ready may change at any time and must
// never depend on valid.
interface stream_demux3_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_sel;
  logic [DW-1:0] in_data;
  logic [2:0]    out_valid;
  logic [2:0]    out_ready;
  logic [DW-1:0] out_data;

  // Producer of input beats and consumer of the output channels.
  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // The demultiplexer itself.
  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/stream_demux3.sv
// 1-to-3 stream demultiplexer with a one-entry registered output stage.
// A beat with select 0..2 is held in the stage and presented on that
// channel on the following cycle. A beat with select 3 is accepted and
// dropped, and the drop is recorded in a sticky flag and a saturating
// counter. A stalled channel blocks every channel (head-of-line).
module stream_demux3 #(
  parameter int DW    = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  stream_demux3_if.slave   s,
  input  logic             err_clr,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_cnt,
  output logic             dbg_full
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t        state_q, state_d;
  logic [1:0]    dest_q, dest_d;
  logic [DW-1:0] data_q, data_d;

  logic full;
  logic chan_ready;
  logic drain;
  logic in_ready;
  logic acc;
  logic legal;
  logic illegal_acc;

  assign full = (state_q == FULL);

  // Ready of the channel the held beat is waiting on.
  always_comb begin
    chan_ready = 1'b0;
    case (dest_q)
      2'd0:    chan_ready = s.out_ready[0];
      2'd1:    chan_ready = s.out_ready[1];
      2'd2:    chan_ready = s.out_ready[2];
      default: chan_ready = 1'b0;
    endcase
  end

  // The stage can take a new beat when empty or when it empties this cycle.
  assign drain       = full & chan_ready;
  assign in_ready    = ~full | drain;
  assign acc         = s.in_valid & in_ready;
  assign legal       = (s.in_sel != 2'd3);
  assign illegal_acc = acc & ~legal;

  assign s.in_ready  = in_ready;
  assign s.out_data  = data_q;
  assign dbg_full    = full;

  // Per-channel valid decode from the held destination.
  always_comb begin
    s.out_valid = 3'b000;
    if (full) begin
      case (dest_q)
        2'd0:    s.out_valid = 3'b001;
        2'd1:    s.out_valid = 3'b010;
        2'd2:    s.out_valid = 3'b100;
        default: s.out_valid = 3'b000;
      endcase
    end
  end

  // Next state: drain empties the stage, a legal accept (re)fills it.
  // Illegal beats never touch dest or data.
  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    data_d  = data_q;
    if (drain) begin
      state_d = EMPTY;
    end
    if (acc && legal) begin
      state_d = FULL;
      dest_d  = s.in_sel;
      data_d  = s.in_data;
    end
  end

  // Output stage registers; reset discards any held beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      dest_q  <= 2'd0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      data_q  <= data_d;
    end
  end

  // Illegal-select bookkeeping; a new drop wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flag <= 1'b0;
      err_cnt  <= '0;
    end else if (illegal_acc) begin
      err_flag <= 1'b1;
      if (err_clr) begin
        err_cnt <= CNT_ONE;
      end else if (err_cnt != CNT_MAX) begin
        err_cnt <= err_cnt + CNT_ONE;
      end
    end else if (err_clr) begin
      err_flag <= 1'b0;
      err_cnt  <= '0;
    end
  end

endmodule
